delay_tap_scheduler: RTL and testbench
======================================

DELAY_TAP_SCHEDULER -- requirements
Module: delay_tap_scheduler

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 16: delay RAM address width; depth 2^ADDR_WIDTH.
REQ-002 SHALL have parameter DATA_WIDTH, default 32: sample width.
REQ-003 SHALL have parameter NUM_TAPS, default 4: taps sharing one RAM read port, range 1..16.
REQ-004 SHALL have parameter RAM_LATENCY, default 2: read address to read data latency of the external RAM, in cycles.
REQ-005 SHALL have port clk, input, 1: clock.
REQ-006 SHALL have port rst, input, 1: reset; rst is synchronous, active-high; clock clk.
REQ-007 SHALL have port sample_valid, input, 1: one-cycle strobe marking a new input sample.
REQ-008 SHALL have port in_sample, input, DATA_WIDTH: new sample.
REQ-009 SHALL have port tap_delay, input, NUM_TAPS x ADDR_WIDTH: per-tap target delay in samples.
REQ-010 SHALL have port ram_we, output, 1: RAM write enable.
REQ-011 SHALL have port ram_wr_addr, output, ADDR_WIDTH: RAM write address.
REQ-012 SHALL have port ram_wr_data, output, DATA_WIDTH: RAM write data.
REQ-013 SHALL have port ram_rd_addr, output, ADDR_WIDTH: RAM read address.
REQ-014 SHALL have port ram_rd_data, input, DATA_WIDTH: RAM read data.
REQ-015 SHALL have port tap_out, output, NUM_TAPS x DATA_WIDTH: delayed samples, one per tap.
REQ-016 SHALL have port tap_valid, output, 1: one-cycle strobe when all of tap_out is updated.
REQ-017 SHALL have port busy, output, 1: high while a schedule is in progress, i.e. any state other than IDLE.
REQ-018 SHALL have port overrun, output, 1: one-cycle pulse when sample_valid arrives while busy.

Function
REQ-019 SHALL implement the FSM IDLE -> ISSUE -> DRAIN -> DONE -> IDLE.
REQ-020 In IDLE with sample_valid (accept cycle T), SHALL drive ram_we=1, ram_wr_addr=wr_ptr, ram_wr_data=in_sample, latch base=wr_ptr, increment wr_ptr mod 2^ADDR_WIDTH, and enter ISSUE.
REQ-021 In ISSUE, SHALL drive ram_rd_addr=(base - eff_delay[i]) mod 2^ADDR_WIDTH for tap i=0..NUM_TAPS-1 in cycles T+1..T+NUM_TAPS, one tap per cycle, ascending.
REQ-022 Read data for tap i SHALL be captured from ram_rd_data exactly RAM_LATENCY cycles after its address was issued, using a valid/index shift pipeline.
REQ-023 DRAIN SHALL last RAM_LATENCY cycles; DONE SHALL assert tap_valid for one cycle and present all captured taps on tap_out simultaneously.
REQ-024 tap_valid SHALL rise at cycle T+NUM_TAPS+RAM_LATENCY+1; tap_out SHALL hold its value between tap_valid strobes.
REQ-025 Delay 0 SHALL return the sample written at T; delay d SHALL return the sample accepted d accepts earlier; address wrap-around SHALL be modular with no special case.
REQ-026 sample_valid while busy SHALL be dropped: no write, no wr_ptr change, overrun=1 for that cycle, schedule in progress unaffected.
REQ-027 sample_valid in the DONE cycle SHALL count as busy (REQ-026); sample_valid in IDLE the cycle after DONE SHALL be accepted.
REQ-028 eff_delay[i] SHALL be sampled once per accept cycle; tap_delay changes mid-schedule SHALL take effect at the next accept.
REQ-029 ram_we SHALL be 0 in every cycle other than the accept cycle.

Reset
REQ-030 rst SHALL set state=IDLE, wr_ptr=0, base=0, tap_out=all 0, tap_valid=0, busy=0, overrun=0, ram_we=0, ram_rd_addr=0, read pipeline valid bits=0, and ramp registers=0.
REQ-031 rst during any state SHALL abort the schedule with no tap_valid; RAM contents SHALL NOT be cleared.

Configuration
REQ-032 With DELAY_RAMP_EN defined, eff_delay[i] SHALL be a register moving toward tap_delay[i] by exactly 1 per accepted sample, or holding when equal; this avoids zipper artefacts.
REQ-033 Without DELAY_RAMP_EN, eff_delay[i] SHALL equal tap_delay[i] sampled in the accept cycle, and no ramp registers SHALL exist.

Structure
REQ-034 SHALL place the FSM state enum and an RAM_LATENCY_DEFAULT constant in shared package audio_delay_pkg.
REQ-035 SHALL instantiate one sub-module delay_ramp, per tap, a single-step slew register present only under DELAY_RAMP_EN.
REQ-036 The RAM SHALL be external; the bench SHALL model it as a read-first dual-port RAM with RAM_LATENCY=2.

Verification
REQ-037 Reset, then 8 accepts of samples 1..8 with tap_delay={0,1,3,7} -> on the 8th tap_valid, tap_out={8,7,5,1}.
REQ-038 Single accept at T=10 with NUM_TAPS=4 -> tap_valid at cycle 17; busy high for cycles 11..17.
REQ-039 sample_valid at T+2 and again in the DONE cycle -> overrun pulses twice, wr_ptr advances by 1 only.
REQ-040 ADDR_WIDTH=4, 20 accepts, delay 5 -> correct sample across pointer wrap (accept 20 returns sample 15).
REQ-041 DELAY_RAMP_EN with tap_delay 0 -> 4 -> eff_delay steps 1,2,3,4 over 4 accepts, then holds.
REQ-042 rst asserted in DRAIN -> no tap_valid; tap_out=0; the next accept writes address 0.

Source files
------------

// File: rtl/audio_delay_pkg.sv
// Shared definitions for the delay tap scheduler.
//   sched_state_e       : scheduler FSM states
//   RAM_LATENCY_DEFAULT : default read latency of the external delay RAM
//   idx_width()         : counter width for a count range of n (at least 1 bit)
package audio_delay_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } sched_state_e;

  localparam int RAM_LATENCY_DEFAULT = 2;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/delay_ramp.sv
// Single-step slew register for one tap delay. Only used when DELAY_RAMP_EN
// is defined.
// Ports:
//   clk, rst   : clock, synchronous active-high reset (clears the delay to 0)
//   step_en    : one step toward target is taken in this cycle
//   target     : requested delay in samples
//   eff_next   : value the register takes if stepped this cycle
//   eff_delay  : current effective delay
module delay_ramp #(
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  step_en,
  input  logic [ADDR_WIDTH-1:0] target,
  output logic [ADDR_WIDTH-1:0] eff_next,
  output logic [ADDR_WIDTH-1:0] eff_delay
);

  logic [ADDR_WIDTH-1:0] eff_r;
  logic [ADDR_WIDTH-1:0] step_s;

  // One sample of movement toward the target, or hold when already there
  always_comb begin
    step_s = eff_r;
    if (eff_r < target) begin
      step_s = eff_r + ADDR_WIDTH'(1);
    end else if (eff_r > target) begin
      step_s = eff_r - ADDR_WIDTH'(1);
    end else begin
      step_s = eff_r;
    end
  end

  // Effective delay register, advanced once per accepted sample
  always_ff @(posedge clk) begin
    if (rst) begin
      eff_r <= {ADDR_WIDTH{1'b0}};
    end else if (step_en) begin
      eff_r <= step_s;
    end else begin
      eff_r <= eff_r;
    end
  end

  assign eff_next  = step_s;
  assign eff_delay = eff_r;

endmodule

// File: rtl/delay_tap_scheduler.sv
// Multi-tap delay line scheduler sharing one external RAM read port.
// Each accepted sample is written to the RAM; then one read per tap is issued
// (ascending tap order), the reads are collected RAM_LATENCY cycles later and
// all taps are presented together with a one-cycle tap_valid strobe.
// Optional feature: define DELAY_RAMP_EN to slew each tap delay toward its
// target by one sample per accept instead of jumping.
// Ports:
//   clk, rst                  : clock, synchronous active-high reset
//   sample_valid, in_sample   : new-sample strobe and data
//   tap_delay                 : NUM_TAPS packed delays, tap 0 in the LSBs
//   ram_we/ram_wr_addr/ram_wr_data : RAM write port
//   ram_rd_addr/ram_rd_data   : RAM read port (data RAM_LATENCY cycles later)
//   tap_out, tap_valid        : delayed samples (tap 0 in LSBs) and strobe
//   busy                      : schedule in progress
//   overrun                   : sample dropped because busy
module delay_tap_scheduler
  import audio_delay_pkg::*;
#(
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_TAPS    = 4,
  parameter int RAM_LATENCY = RAM_LATENCY_DEFAULT
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           sample_valid,
  input  logic [DATA_WIDTH-1:0]          in_sample,
  input  logic [NUM_TAPS*ADDR_WIDTH-1:0] tap_delay,
  output logic                           ram_we,
  output logic [ADDR_WIDTH-1:0]          ram_wr_addr,
  output logic [DATA_WIDTH-1:0]          ram_wr_data,
  output logic [ADDR_WIDTH-1:0]          ram_rd_addr,
  input  logic [DATA_WIDTH-1:0]          ram_rd_data,
  output logic [NUM_TAPS*DATA_WIDTH-1:0] tap_out,
  output logic                           tap_valid,
  output logic                           busy,
  output logic                           overrun
);

  localparam int IW = idx_width(NUM_TAPS);
  localparam int CW = idx_width(RAM_LATENCY);

  sched_state_e          state_r, state_nxt_s;
  logic [ADDR_WIDTH-1:0] wr_ptr_r, base_r, rd_addr_r;
  logic [IW-1:0]         idx_r;
  logic [CW-1:0]         drain_r;
  logic                  accept_s, issue_s, last_issue_s, last_drain_s;

  // eff_at_accept_s: delay used by a schedule accepted this cycle
  // eff_delay_s    : delay held for the schedule in progress
  logic [ADDR_WIDTH-1:0] eff_at_accept_s [NUM_TAPS];
  logic [ADDR_WIDTH-1:0] eff_delay_s     [NUM_TAPS];

  logic [RAM_LATENCY-1:0] vld_pipe_r;
  logic [IW-1:0]          idx_pipe_r [RAM_LATENCY];
  logic [DATA_WIDTH-1:0]  cap_r      [NUM_TAPS];
  logic [DATA_WIDTH-1:0]  cap_nxt_s  [NUM_TAPS];
  logic [NUM_TAPS*DATA_WIDTH-1:0] tap_out_r;
  logic                   tap_valid_r;

  assign accept_s     = (state_r == ST_IDLE) && sample_valid && !rst;
  assign issue_s      = (state_r == ST_ISSUE);
  assign last_issue_s = issue_s && (idx_r == IW'(NUM_TAPS - 1));
  assign last_drain_s = (state_r == ST_DRAIN) && (drain_r == CW'(RAM_LATENCY - 1));

`ifdef DELAY_RAMP_EN
  for (genvar g = 0; g < NUM_TAPS; g++) begin : g_ramp
    delay_ramp #(.ADDR_WIDTH(ADDR_WIDTH)) u_ramp (
      .clk      (clk),
      .rst      (rst),
      .step_en  (accept_s),
      .target   (tap_delay[g*ADDR_WIDTH +: ADDR_WIDTH]),
      .eff_next (eff_at_accept_s[g]),
      .eff_delay(eff_delay_s[g])
    );
  end
`else
  logic [ADDR_WIDTH-1:0] delay_cap_r [NUM_TAPS];

  for (genvar g = 0; g < NUM_TAPS; g++) begin : g_direct
    assign eff_at_accept_s[g] = tap_delay[g*ADDR_WIDTH +: ADDR_WIDTH];
  end

  // Snapshot of the requested delays, frozen for the whole schedule
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_TAPS; i++) delay_cap_r[i] <= {ADDR_WIDTH{1'b0}};
    end else if (accept_s) begin
      for (int i = 0; i < NUM_TAPS; i++) delay_cap_r[i] <= eff_at_accept_s[i];
    end else begin
      delay_cap_r <= delay_cap_r;
    end
  end

  assign eff_delay_s = delay_cap_r;
`endif

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state_r <= ST_IDLE;
    else     state_r <= state_nxt_s;
  end

  // FSM next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE:  if (sample_valid) state_nxt_s = ST_ISSUE; else state_nxt_s = ST_IDLE;
      ST_ISSUE: if (last_issue_s) state_nxt_s = ST_DRAIN; else state_nxt_s = ST_ISSUE;
      ST_DRAIN: if (last_drain_s) state_nxt_s = ST_DONE;  else state_nxt_s = ST_DRAIN;
      ST_DONE:  state_nxt_s = ST_IDLE;
      default:  state_nxt_s = ST_IDLE;
    endcase
  end

  // Write pointer, base address, tap index and the registered read address.
  // The first read address is prepared in the accept cycle so that tap 0 is
  // on the bus in the first ISSUE cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r  <= {ADDR_WIDTH{1'b0}};
      base_r    <= {ADDR_WIDTH{1'b0}};
      rd_addr_r <= {ADDR_WIDTH{1'b0}};
      idx_r     <= {IW{1'b0}};
      drain_r   <= {CW{1'b0}};
    end else begin
      if (accept_s) begin
        wr_ptr_r  <= wr_ptr_r + ADDR_WIDTH'(1);
        base_r    <= wr_ptr_r;
        rd_addr_r <= wr_ptr_r - eff_at_accept_s[0];
        idx_r     <= {IW{1'b0}};
      end else if (issue_s && !last_issue_s) begin
        idx_r     <= idx_r + IW'(1);
        rd_addr_r <= base_r - eff_delay_s[idx_r + IW'(1)];
      end else begin
        idx_r     <= idx_r;
        rd_addr_r <= rd_addr_r;
      end
      if (state_r == ST_DRAIN) drain_r <= drain_r + CW'(1);
      else                     drain_r <= {CW{1'b0}};
    end
  end

  // Valid/index shift pipeline matching the RAM read latency
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe_r <= {RAM_LATENCY{1'b0}};
      for (int k = 0; k < RAM_LATENCY; k++) idx_pipe_r[k] <= {IW{1'b0}};
    end else begin
      vld_pipe_r[0] <= issue_s;
      idx_pipe_r[0] <= idx_r;
      for (int k = 1; k < RAM_LATENCY; k++) begin
        vld_pipe_r[k] <= vld_pipe_r[k-1];
        idx_pipe_r[k] <= idx_pipe_r[k-1];
      end
    end
  end

  // Capture array with this cycle's returning read data merged in
  always_comb begin
    cap_nxt_s = cap_r;
    if (vld_pipe_r[RAM_LATENCY-1]) begin
      cap_nxt_s[idx_pipe_r[RAM_LATENCY-1]] = ram_rd_data;
    end else begin
      cap_nxt_s = cap_r;
    end
  end

  // Capture registers and output presentation; the last tap arrives on the
  // final DRAIN cycle, so tap_out loads from the merged view at that edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_TAPS; i++) cap_r[i] <= {DATA_WIDTH{1'b0}};
      tap_out_r   <= {(NUM_TAPS*DATA_WIDTH){1'b0}};
      tap_valid_r <= 1'b0;
    end else begin
      cap_r       <= cap_nxt_s;
      tap_valid_r <= last_drain_s;
      if (last_drain_s) begin
        for (int i = 0; i < NUM_TAPS; i++) tap_out_r[i*DATA_WIDTH +: DATA_WIDTH] <= cap_nxt_s[i];
      end else begin
        tap_out_r <= tap_out_r;
      end
    end
  end

  assign ram_we      = accept_s;
  assign ram_wr_addr = wr_ptr_r;
  assign ram_wr_data = in_sample;
  assign ram_rd_addr = rd_addr_r;
  assign tap_out     = tap_out_r;
  assign tap_valid   = tap_valid_r;
  assign busy        = (state_r != ST_IDLE);
  assign overrun     = sample_valid && (state_r != ST_IDLE) && !rst;

endmodule

// File: tb/tb_delay_tap_scheduler.sv
// Directed testbench for delay_tap_scheduler with a read-first dual-port RAM
// model of latency 2. Small address space (ADDR_WIDTH=4) so wrap-around is
// reached quickly.
module tb_delay_tap_scheduler;

  localparam int AW = 4;
  localparam int DW = 16;
  localparam int NT = 4;
  localparam int RL = 2;

  logic              clk, rst, sample_valid;
  logic [DW-1:0]     in_sample;
  logic [NT*AW-1:0]  tap_delay;
  logic              ram_we;
  logic [AW-1:0]     ram_wr_addr, ram_rd_addr;
  logic [DW-1:0]     ram_wr_data, ram_rd_data;
  logic [NT*DW-1:0]  tap_out;
  logic              tap_valid, busy, overrun;

  int vec_cnt = 0;
  int err_cnt = 0;
  int ovr_seen = 0;
  int ovr_before;

  logic [AW-1:0] del_m [NT];
  logic [AW-1:0] eff_m [NT];
  logic [AW-1:0] cap_m [NT];
  logic [AW-1:0] wr_ptr_m, base_m;

  delay_tap_scheduler #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_TAPS(NT), .RAM_LATENCY(RL)
  ) dut (
    .clk(clk), .rst(rst), .sample_valid(sample_valid), .in_sample(in_sample),
    .tap_delay(tap_delay), .ram_we(ram_we), .ram_wr_addr(ram_wr_addr),
    .ram_wr_data(ram_wr_data), .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data),
    .tap_out(tap_out), .tap_valid(tap_valid), .busy(busy), .overrun(overrun)
  );

  // External RAM: read-first, two-cycle read latency
  logic [DW-1:0] mem [2**AW];
  logic [DW-1:0] rd1, rd2;
  always @(posedge clk) begin
    if (ram_we) mem[ram_wr_addr] <= ram_wr_data;
    rd1 <= mem[ram_rd_addr];
    rd2 <= rd1;
  end
  assign ram_rd_data = rd2;

  // Overrun pulse counter
  always @(posedge clk) if (overrun) ovr_seen <= ovr_seen + 1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic set_delays(input int d0, input int d1, input int d2, input int d3);
    del_m[0] = AW'(d0); del_m[1] = AW'(d1); del_m[2] = AW'(d2); del_m[3] = AW'(d3);
    tap_delay = {del_m[3], del_m[2], del_m[1], del_m[0]};
  endtask

  task automatic chk_taps(input int e0, input int e1, input int e2, input int e3);
    chk("tap0", 64'(tap_out[0*DW +: DW]), 64'(e0));
    chk("tap1", 64'(tap_out[1*DW +: DW]), 64'(e1));
    chk("tap2", 64'(tap_out[2*DW +: DW]), 64'(e2));
    chk("tap3", 64'(tap_out[3*DW +: DW]), 64'(e3));
  endtask

  // Drive one accepted sample; returns in the first ISSUE cycle
  task automatic accept(input int s);
    for (int i = 0; i < NT; i++) begin
`ifdef DELAY_RAMP_EN
      if (eff_m[i] < del_m[i])      eff_m[i] = eff_m[i] + AW'(1);
      else if (eff_m[i] > del_m[i]) eff_m[i] = eff_m[i] - AW'(1);
`else
      eff_m[i] = del_m[i];
`endif
      cap_m[i] = eff_m[i];
    end
    base_m = wr_ptr_m;
    sample_valid = 1'b1;
    in_sample = DW'(s);
    #1;
    chk("ram_we", 64'(ram_we), 64'd1);
    chk("wr_addr", 64'(ram_wr_addr), 64'(wr_ptr_m));
    chk("wr_data", 64'(ram_wr_data), 64'(s));
    chk("busy_idle", 64'(busy), 64'd0);
    wr_ptr_m = wr_ptr_m + AW'(1);
    step();
    sample_valid = 1'b0;
  endtask

  // Cycles T+1..T+8: read addresses, busy window and tap_valid timing
  task automatic window();
    logic [AW-1:0] ea;
    for (int n = 1; n <= 8; n++) begin
      #1;
      chk("busy", 64'(busy), 64'(n <= NT + RL + 1));
      chk("tap_valid", 64'(tap_valid), 64'(n == NT + RL + 1));
      chk("ram_we_quiet", 64'(ram_we), 64'd0);
      if (n <= NT) begin
        ea = base_m - cap_m[n-1];
        chk("rd_addr", 64'(ram_rd_addr), 64'(ea));
      end
      step();
    end
  endtask

  task automatic run_sched(input int s);
    accept(s);
    window();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    wr_ptr_m = '0;
    for (int i = 0; i < NT; i++) eff_m[i] = '0;
  endtask

  initial begin
    sample_valid = 1'b0;
    in_sample = '0;
    set_delays(0, 0, 0, 0);
    do_reset();
    #1;
    chk("rst_tap_valid", 64'(tap_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_overrun", 64'(overrun), 64'd0);
    chk("rst_ram_we", 64'(ram_we), 64'd0);
    chk("rst_rd_addr", 64'(ram_rd_addr), 64'd0);
    chk("rst_tap_out", 64'(tap_out), 64'd0);
    step();

`ifdef DELAY_RAMP_EN
    // Delay target jumps 0 -> 4: effective delay 1,2,3,4 then holds
    set_delays(4, 4, 4, 4);
    for (int k = 1; k <= 6; k++) run_sched(k);
    chk_taps(2, 2, 2, 2);
`else
    // Eight accepts, mixed delays
    set_delays(0, 1, 3, 7);
    for (int k = 1; k <= 8; k++) run_sched(k);
    chk_taps(8, 7, 5, 1);

    // Overruns at T+2 and in the DONE cycle; next IDLE cycle accepts
    accept(9);
    ovr_before = ovr_seen;
    step();
    sample_valid = 1'b1; in_sample = 16'd99; #1;
    chk("ovr_t2", 64'(overrun), 64'd1);
    chk("ovr_t2_we", 64'(ram_we), 64'd0);
    step();
    sample_valid = 1'b0;
    repeat (4) step();
    #1;
    chk("done_valid", 64'(tap_valid), 64'd1);
    chk_taps(9, 8, 6, 2);
    sample_valid = 1'b1; in_sample = 16'd98; #1;
    chk("ovr_done", 64'(overrun), 64'd1);
    chk("ovr_done_we", 64'(ram_we), 64'd0);
    step();
    accept(10);
    // Delay change mid-schedule must not affect this schedule
    set_delays(0, 5, 15, 1);
    window();
    chk_taps(10, 9, 7, 3);
    chk("ovr_count", 64'(ovr_seen - ovr_before), 64'd2);

    // Reset in DRAIN aborts the schedule
    accept(200);
    repeat (4) step();
    #1;
    chk("drain_busy", 64'(busy), 64'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    wr_ptr_m = '0;
    for (int n = 0; n < 10; n++) begin
      #1;
      chk("abort_no_valid", 64'(tap_valid), 64'd0);
      step();
    end
    chk("abort_busy", 64'(busy), 64'd0);
    chk_taps(0, 0, 0, 0);

    // Twenty accepts across the 16-entry wrap, first one writes address 0
    for (int k = 1; k <= 20; k++) run_sched(100 + k);
    chk_taps(120, 115, 105, 119);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
